// File: rtl/regread_pkg.sv
`default_nettype none
// regread_pkg: shared state type and constants for the operand-fetch sequencer.
// Revision: 1.0
package regread_pkg;

  localparam int DEFAULT_AW = 5;
  localparam int DEFAULT_DW = 32;

  // Register 0 is hardwired to zero in the register file.
  localparam logic [DEFAULT_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/regread_seq_if.sv
`default_nettype none
// regread_seq_if: control-FSM and register-file port bundle for regread_seq.
// Revision: 1.0
interface regread_seq_if
  import regread_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int NUM_SRC = 4
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                  start;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic [SW-1:0]         sel_a;
  logic [SW-1:0]         sel_b;
  logic [AW-1:0]         rf_raddr;
  logic                  rf_re;
  logic [DW-1:0]         rf_rdata;
  logic [DW-1:0]         a_out;
  logic [DW-1:0]         b_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, src_addr, sel_a, sel_b, rf_rdata,
    input  rf_raddr, rf_re, a_out, b_out, busy, done
  );

  modport slave (
    input  start, src_addr, sel_a, sel_b, rf_rdata,
    output rf_raddr, rf_re, a_out, b_out, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/regread_seq_src_addr_mux.sv
`default_nettype none
// src_addr_mux: NUM_SRC:1 register-address selector; out-of-range select yields register 0.
// Revision: 1.0
module src_addr_mux
  import regread_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int NUM_SRC = 4,
  parameter int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [SW-1:0]         sel,
  output logic [AW-1:0]         addr
);

  always_comb begin
    addr = AW'(ZERO_REG);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(sel) == i) addr = src_addr[i*AW +: AW];
    end
  end

endmodule
`default_nettype wire

// File: rtl/regread_seq.sv
`default_nettype none
// regread_seq: serialised two-operand fetch through one register-file read port.
// Optional macro REGREAD_SKIP_DUP_EN: single read when both operands name the same register. Revision: 1.0
module regread_seq
  import regread_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int NUM_SRC = 4
) (
  input  logic           clk,
  input  logic           reset,
  regread_seq_if.slave   bus
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t        state;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] mux_a;
  logic [AW-1:0] mux_b;
  logic [AW-1:0] raddr;
  logic          re;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] rd_val;

  src_addr_mux #(.AW(AW), .NUM_SRC(NUM_SRC), .SW(SW)) u_mux_a (
    .src_addr (bus.src_addr),
    .sel      (bus.sel_a),
    .addr     (mux_a)
  );

  src_addr_mux #(.AW(AW), .NUM_SRC(NUM_SRC), .SW(SW)) u_mux_b (
    .src_addr (bus.src_addr),
    .sel      (bus.sel_b),
    .addr     (mux_b)
  );

  // The registered read address is the one being fetched, so the zero rule keys off it.
  assign rd_val = (raddr == AW'(ZERO_REG)) ? '0 : bus.rf_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_a <= '0;
      addr_b <= '0;
      raddr  <= '0;
      re     <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_a <= mux_a;
            addr_b <= mux_b;
            raddr  <= mux_a;
            re     <= 1'b1;
            busy_q <= 1'b1;
            state  <= RD_A;
          end
        end
        RD_A: begin
          a_q <= rd_val;
`ifdef REGREAD_SKIP_DUP_EN
          if (addr_a == addr_b) begin
            b_q    <= rd_val;
            raddr  <= '0;
            re     <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            raddr <= addr_b;
            state <= RD_B;
          end
`else
          raddr <= addr_b;
          state <= RD_B;
`endif
        end
        RD_B: begin
          b_q    <= rd_val;
          raddr  <= '0;
          re     <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rf_raddr = raddr;
  assign bus.rf_re    = re;
  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regread_seq.sv
`default_nettype none
// tb_regread_seq: randomized and directed checks of regread_seq against a behavioural operand-fetch model.
// Revision: 1.0
module tb_regread_seq;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int NUM_SRC = 4;
  localparam int SW      = 2;
  localparam int SRCW    = NUM_SRC * AW;
`ifdef REGREAD_SKIP_DUP_EN
  localparam bit SKIP_DUP = 1'b1;
`else
  localparam bit SKIP_DUP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [DW-1:0] regs [0:31];

  regread_seq_if #(.AW(AW), .DW(DW), .NUM_SRC(NUM_SRC)) bus ();

  regread_seq #(.AW(AW), .DW(DW), .NUM_SRC(NUM_SRC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.rf_rdata = regs[bus.rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the last fetch (cycle k = period after acceptance edge k-1).
  int            n_done, done_cyc, n_re, n_busy;
  logic          idle_bad;
  logic [AW-1:0] raddr1, raddr2;

  function automatic logic [AW-1:0] ref_addr(input logic [SRCW-1:0] src, input logic [SW-1:0] sel);
    if (int'(sel) >= NUM_SRC) return '0;
    return src[int'(sel)*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : regs[addr];
  endfunction

  function automatic int ref_latency(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (SKIP_DUP && a == b) ? 2 : 3;
  endfunction

  task automatic fill_offset();
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
  endtask

  // Issue one start at the next edge and record six cycles of port activity.
  task automatic do_fetch(input logic [SRCW-1:0] src, input logic [SW-1:0] sa,
                          input logic [SW-1:0] sb, input bit disturb);
    n_done = 0; done_cyc = 0; n_re = 0; n_busy = 0; idle_bad = 1'b0;
    raddr1 = '0; raddr2 = '0;
    bus.src_addr = src; bus.sel_a = sa; bus.sel_b = sb; bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) begin
      bus.start = disturb && (k <= 3);
      if (disturb) begin
        bus.sel_a    = sa + 1'b1;
        bus.src_addr = SRCW'($urandom);
      end
      @(negedge clk);
      if (bus.done) begin n_done++; if (done_cyc == 0) done_cyc = k; end
      if (bus.rf_re) n_re++;
      else if (bus.rf_raddr != '0) idle_bad = 1'b1;
      if (bus.busy) n_busy++;
      if (k == 1) raddr1 = bus.rf_raddr;
      if (k == 2) raddr2 = bus.rf_raddr;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.src_addr = '0; bus.sel_a = '0; bus.sel_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.a_out !== '0) begin failures++; $display("FAIL reset_a cyc=%0d got=%h exp=0", c, bus.a_out); end
      checks++; if (bus.b_out !== '0) begin failures++; $display("FAIL reset_b cyc=%0d got=%h exp=0", c, bus.b_out); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done cyc=%0d got=%b exp=0", c, bus.done); end
      checks++; if (bus.rf_re !== 1'b0) begin failures++; $display("FAIL reset_re cyc=%0d got=%b exp=0", c, bus.rf_re); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fill_offset();
    do_fetch({5'd31, 5'd9, 5'd8, 5'd4}, 2'd1, 2'd2, 1'b0);
    checks++; if (raddr1 !== 5'd8) begin failures++; $display("FAIL basic_raddr1 got=%0d exp=8", raddr1); end
    checks++; if (raddr2 !== 5'd9) begin failures++; $display("FAIL basic_raddr2 got=%0d exp=9", raddr2); end
    checks++; if (done_cyc != 3 || n_done != 1) begin failures++; $display("FAIL basic_done cyc=%0d n=%0d exp cyc=3 n=1", done_cyc, n_done); end
    checks++; if (n_re != 2 || idle_bad) begin failures++; $display("FAIL basic_re n=%0d idle_bad=%b exp n=2 idle_bad=0", n_re, idle_bad); end
    checks++; if (bus.a_out !== 32'h108) begin failures++; $display("FAIL basic_a got=%h exp=108", bus.a_out); end
    checks++; if (bus.b_out !== 32'h109) begin failures++; $display("FAIL basic_b got=%h exp=109", bus.b_out); end
  endtask

  task automatic test_zero_reg();
    fill_offset();
    regs[0] = 32'hDEADBEEF;
    do_fetch({5'd31, 5'd9, 5'd8, 5'd0}, 2'd0, 2'd1, 1'b0);
    checks++; if (bus.a_out !== '0) begin failures++; $display("FAIL zero_a got=%h exp=0", bus.a_out); end
    checks++; if (bus.b_out !== 32'h108) begin failures++; $display("FAIL zero_b got=%h exp=108", bus.b_out); end
    checks++; if (n_re != 2) begin failures++; $display("FAIL zero_re n=%0d exp=2", n_re); end
  endtask

  task automatic test_busy_ignore();
    fill_offset();
    do_fetch({5'd31, 5'd9, 5'd8, 5'd4}, 2'd3, 2'd2, 1'b1);
    checks++; if (n_done != 1) begin failures++; $display("FAIL ignore_ndone got=%0d exp=1", n_done); end
    checks++; if (n_busy != 3) begin failures++; $display("FAIL ignore_busy got=%0d exp=3", n_busy); end
    checks++; if (raddr1 !== 5'd31 || raddr2 !== 5'd9) begin failures++; $display("FAIL ignore_addr got=%0d,%0d exp=31,9", raddr1, raddr2); end
    checks++; if (bus.a_out !== 32'h11F || bus.b_out !== 32'h109) begin failures++; $display("FAIL ignore_data got=%h,%h exp=11f,109", bus.a_out, bus.b_out); end
  endtask

  task automatic test_reset_mid();
    fill_offset();
    bus.src_addr = {5'd31, 5'd9, 5'd8, 5'd4}; bus.sel_a = 2'd1; bus.sel_b = 2'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.rf_raddr !== 5'd9) begin failures++; $display("FAIL mid_rdb busy=%b raddr=%0d exp 1,9", bus.busy, bus.rf_raddr); end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rf_re !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl busy=%b done=%b re=%b exp 0,0,0", bus.busy, bus.done, bus.rf_re); end
    checks++; if (bus.a_out !== '0 || bus.b_out !== '0) begin failures++; $display("FAIL mid_rst_data got=%h,%h exp=0,0", bus.a_out, bus.b_out); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mid_late_done got=%b exp=0", bus.done); end
    bus.start = 1'b1; reset = 1'b1;
    @(posedge clk); #1 begin bus.start = 1'b0; reset = 1'b0; end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.rf_re !== 1'b0) begin failures++; $display("FAIL rst_start busy=%b re=%b exp 0,0", bus.busy, bus.rf_re); end
    do_fetch({5'd31, 5'd9, 5'd8, 5'd4}, 2'd2, 2'd1, 1'b0);
    checks++; if (done_cyc != 3 || n_done != 1) begin failures++; $display("FAIL mid_refetch cyc=%0d n=%0d exp 3,1", done_cyc, n_done); end
    checks++; if (bus.a_out !== 32'h109 || bus.b_out !== 32'h108) begin failures++; $display("FAIL mid_refetch_data got=%h,%h exp=109,108", bus.a_out, bus.b_out); end
  endtask

  task automatic test_dup();
    int lat;
    fill_offset();
    lat = SKIP_DUP ? 2 : 3;
    do_fetch({5'd31, 5'd9, 5'd8, 5'd4}, 2'd1, 2'd1, 1'b0);
    checks++; if (done_cyc != lat || n_done != 1) begin failures++; $display("FAIL dup_done cyc=%0d n=%0d exp %0d,1", done_cyc, n_done, lat); end
    checks++; if (n_re != lat - 1 || idle_bad) begin failures++; $display("FAIL dup_re n=%0d idle_bad=%b exp %0d,0", n_re, idle_bad, lat - 1); end
    checks++; if (bus.a_out !== 32'h108 || bus.b_out !== 32'h108) begin failures++; $display("FAIL dup_data got=%h,%h exp=108,108", bus.a_out, bus.b_out); end
  endtask

  task automatic test_random();
    logic [SRCW-1:0] src;
    logic [SW-1:0]   sa, sb;
    logic [AW-1:0]   aa, ab, exp_r2;
    logic [DW-1:0]   ea, eb;
    int              lat;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      src = SRCW'($urandom);
      sa  = SW'($urandom_range(0, NUM_SRC - 1));
      sb  = SW'($urandom_range(0, NUM_SRC - 1));
      if (it % 5 == 0) sb = sa;
      if (it % 7 == 0) begin src[AW-1:0] = '0; sa = '0; end
      aa = ref_addr(src, sa); ab = ref_addr(src, sb);
      ea = ref_read(aa);      eb = ref_read(ab);
      lat = ref_latency(aa, ab);
      exp_r2 = (lat == 3) ? ab : '0;
      do_fetch(src, sa, sb, 1'b0);
      checks++; if (done_cyc != lat || n_done != 1 || n_busy != lat) begin failures++; $display("FAIL rand_timing it=%0d cyc=%0d n=%0d busy=%0d exp lat=%0d", it, done_cyc, n_done, n_busy, lat); end
      checks++; if (raddr1 !== aa || raddr2 !== exp_r2 || n_re != lat - 1 || idle_bad) begin failures++; $display("FAIL rand_port it=%0d raddr=%0d,%0d re=%0d exp %0d,%0d,%0d", it, raddr1, raddr2, n_re, aa, exp_r2, lat - 1); end
      checks++; if (bus.a_out !== ea || bus.b_out !== eb) begin failures++; $display("FAIL rand_data it=%0d got=%h,%h exp=%h,%h", it, bus.a_out, bus.b_out, ea, eb); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    fill_offset();
    test_reset();
    test_basic();
    test_zero_reg();
    test_busy_ignore();
    test_reset_mid();
    test_dup();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regread_seq.md
Name: regread_seq

Overview:
- Operand-fetch sequencer for the multicycle CPU.
- Selects two register addresses from NUM_SRC candidate sources (rs, rt, rd, $ra, …), reads both through the single shared register-file read port, and latches the A and B operand registers.
- Sits between the control FSM and the register file, replacing fixed 2:1 read-address selection with parametrised N:1 selection and serialised port access.

Parameters:
- AW, 5, register address width
- DW, 32, register data width
- NUM_SRC, 4, number of candidate address sources (>=2); SW = $clog2(NUM_SRC)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request operand fetch; accepted only in IDLE
- src_addr  in  NUM_SRC*AW  flattened sources; source i at [i*AW +: AW]
- sel_a  in  SW  source index for operand A
- sel_b  in  SW  source index for operand B
- rf_raddr  out  AW  register-file read address
- rf_re  out  1  read-port strobe
- rf_rdata  in  DW  register-file read data (combinational, same cycle as rf_raddr)
- a_out  out  DW  latched operand A
- b_out  out  DW  latched operand B
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; a_out/b_out valid

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- States: IDLE, RD_A, RD_B, DONE. Reset drives state to IDLE and a_out, b_out, latched addresses, done and busy to 0.
- IDLE:
  - On start=1, latch addr_a = src_addr[sel_a] and addr_b = src_addr[sel_b].
  - Next state is RD_A.
- RD_A:
  - rf_raddr=addr_a, rf_re=1.
  - At clock edge, a_out <= (addr_a==0) ? 0 : rf_rdata.
  - Next state is RD_B.
- RD_B:
  - rf_raddr=addr_b, rf_re=1.
  - At clock edge, b_out <= (addr_b==0) ? 0 : rf_rdata.
  - Next state is DONE.
- DONE:
  - done=1, rf_re=0.
  - Next state is IDLE unconditionally.
- Outputs outside RD_A/RD_B: rf_raddr=0, rf_re=0.
- Latency: start sampled at edge N gives done=1 in cycle N+3. a_out/b_out hold value until the next fetch overwrites them.
- Boundaries:
  - start while busy, including in DONE: ignored, no queuing.
  - src_addr/sel changes after acceptance: ignored, because addresses are latched.
  - sel >= NUM_SRC (non-power-of-2 NUM_SRC): selects address 0, so the operand reads as 0.
  - Register 0 always yields 0 regardless of rf_rdata.
  - reset asserted in any state: IDLE next cycle, all outputs cleared, no done pulse.
  - reset and start together: reset wins.

Optional Feature:
- Macro: REGREAD_SKIP_DUP_EN.
- Defined: if addr_a==addr_b at acceptance, RD_A transitions directly to DONE and b_out is loaded with the same value as a_out on that edge. Latency becomes 2 cycles; rf_re is asserted for one cycle only.
- Undefined: always two reads, latency 3.

Decomposition:
- Package regread_pkg:
  - state enum (IDLE, RD_A, RD_B, DONE)
  - default AW/DW constants
  - ZERO_REG = '0
- Sub-module src_addr_mux: parametrised NUM_SRC:1, AW-wide combinational address selector with out-of-range→0 rule. Instanced twice, for sel_a and sel_b.

Test Plan:
- Reset, then idle 5 cycles → a_out=b_out=0, busy=0, done=0, rf_re=0 throughout.
- src_addr={31,9,8,4}, sel_a=1, sel_b=2; rf model returns 0x100+addr; start at edge 0 → rf_raddr=8 in cycle 1, 9 in cycle 2; done in cycle 3; a_out=0x108, b_out=0x109.
- sel_a=0 with source 0 = addr 0, rf model drives 0xDEADBEEF → a_out=0.
- Pulse start again in cycles 1–3 of a fetch, and change sel_a mid-fetch → exactly one done pulse; original addresses read.
- Assert reset in RD_B → next cycle IDLE, a_out=b_out=0, no done pulse; a new start then completes normally in 3 cycles.
- With REGREAD_SKIP_DUP_EN, sel_a=sel_b pointing to addr 8 → rf_re high for 1 cycle, done at cycle 2, a_out=b_out=0x108. Without the macro → done at cycle 3.
